// File: rtl/fpu_pkg.sv
// Shared floating-point compare types, widths and field helpers.
package fpu_pkg;

  localparam int         FP_W       = 32;
  localparam int         CMP_RES_W  = 8;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_LE,
    CMP_LT
  } cmp_op_t;

  // Operand classification carried from the holding registers into stage 1.
  typedef struct packed {
    logic            nan_a;
    logic            nan_b;
    logic            both_zero;
    logic            sign_a;
    logic            sign_b;
    logic [FP_W-2:0] mag_a;
    logic [FP_W-2:0] mag_b;
  } cls_t;

  // Exponent all ones with a non-zero mantissa; infinities are not NaN.
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/axis_hold.sv
// One-entry operand holding register with a full flag.
module axis_hold
  import fpu_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic         full
);

  // Full flag: a new transfer wins over the clear of the pair being issued.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // Payload capture.
  // NOTE: the payload has no reset; the full flag alone says whether it means anything.
  always_ff @(posedge aclk) begin
    if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/fcmp_axis.sv
// AXI-Stream IEEE-754 single-precision comparator: pair A/B, classify, compare.
module fcmp_axis
  import fpu_pkg::*;
#(
  parameter cmp_op_t CMP_OP = CMP_EQ
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [FP_W-1:0]      s_axis_a_tdata,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [FP_W-1:0]      s_axis_b_tdata,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  output logic [CMP_RES_W-1:0] m_axis_result_tdata,
  output logic                 m_axis_result_tvalid,
  input  logic                 m_axis_result_tready
);

  logic            a_full, b_full;
  logic [FP_W-1:0] a_data, b_data;
  logic            a_load, b_load;
  logic            s2_en, s1_ready, issue;
  logic            s1_valid;
  cls_t            s1, cls_next;
  logic            is_eq, is_lt, sel, cmp_res;

  // The output register moves whenever it is empty or being drained; stage 1
  // follows it, and a pair issues only into a stage 1 that will have room.
  assign s2_en    = ~m_axis_result_tvalid | m_axis_result_tready;
  assign s1_ready = ~s1_valid | s2_en;
  assign issue    = a_full & b_full & s1_ready;

  // Reset holds off both inputs so nothing is taken while state is cleared.
  assign s_axis_a_tready = aresetn & (~a_full | issue);
  assign s_axis_b_tready = aresetn & (~b_full | issue);
  assign a_load          = s_axis_a_tvalid & s_axis_a_tready;
  assign b_load          = s_axis_b_tvalid & s_axis_b_tready;

  axis_hold #(.W(FP_W)) u_hold_a (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (a_load),
    .clear     (issue),
    .load_data (s_axis_a_tdata),
    .data      (a_data),
    .full      (a_full)
  );

  axis_hold #(.W(FP_W)) u_hold_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (b_load),
    .clear     (issue),
    .load_data (s_axis_b_tdata),
    .data      (b_data),
    .full      (b_full)
  );

  // Classify the held pair; +0 and -0 are folded together via both_zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cls_next           = '0;
    cls_next.nan_a     = fp_is_nan(a_data);
    cls_next.nan_b     = fp_is_nan(b_data);
    cls_next.both_zero = (a_data[FP_W-2:0] == '0) && (b_data[FP_W-2:0] == '0);
    cls_next.sign_a    = a_data[FP_W-1];
    cls_next.sign_b    = b_data[FP_W-1];
    cls_next.mag_a     = a_data[FP_W-2:0];
    cls_next.mag_b     = b_data[FP_W-2:0];
  end

  // Stage 1 valid bit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= issue;
    end
  end

  // Stage 1 classification payload, loaded only when a pair issues.
  always_ff @(posedge aclk) begin
    if (issue) begin
      s1 <= cls_next;
    end
  end

  // Ordering from sign and magnitude; denormals and infinities need no special case.
  always_comb begin
    is_eq   = 1'b0;
    is_lt   = 1'b0;
    sel     = 1'b0;
    cmp_res = 1'b0;

    is_eq = s1.both_zero | ((s1.sign_a == s1.sign_b) & (s1.mag_a == s1.mag_b));

    if (s1.both_zero) begin
      is_lt = 1'b0;
    end else if (s1.sign_a != s1.sign_b) begin
      is_lt = s1.sign_a;
    end else if (!s1.sign_a) begin
      is_lt = s1.mag_a < s1.mag_b;
    end else begin
      is_lt = s1.mag_a > s1.mag_b;
    end

    unique case (CMP_OP)
      CMP_EQ:  sel = is_eq;
      CMP_LE:  sel = is_eq | is_lt;
      CMP_LT:  sel = is_lt;
      default: sel = 1'b0;
    endcase

    cmp_res = ~(s1.nan_a | s1.nan_b) & sel;
  end

  // Output register; holds data and valid steady while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
    end else if (s2_en) begin
      m_axis_result_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_result_tdata <= {{(CMP_RES_W-1){1'b0}}, cmp_res};
      end
    end
  end

endmodule

// File: tb/tb_fcmp_axis.sv
// Bench for fcmp_axis: one instance per compare op, shared stimulus,
// ordered-key reference model and pairing scoreboard.
module tb_fcmp_axis;
  import fpu_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid;
  logic        m_tready;
  logic [2:0]  a_rdy, b_rdy, r_valid;   // index 0 = EQ, 1 = LE, 2 = LT
  logic [7:0]  r_data [3];

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard state
  logic [31:0] qa[$], qb[$];   // transferred, not yet paired
  logic [31:0] ea[$], eb[$];   // paired, awaiting result
  logic        a_xfer, b_xfer;
  logic        prev_stall;
  logic [7:0]  prev_data [3];
  int          cyc, n_results, n_a_xfer, fire_first, fire_last;

  fcmp_axis #(.CMP_OP(CMP_EQ)) dut_eq (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_rdy[0]),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_rdy[0]),
    .m_axis_result_tdata(r_data[0]), .m_axis_result_tvalid(r_valid[0]),
    .m_axis_result_tready(m_tready)
  );

  fcmp_axis #(.CMP_OP(CMP_LE)) dut_le (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_rdy[1]),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_rdy[1]),
    .m_axis_result_tdata(r_data[1]), .m_axis_result_tvalid(r_valid[1]),
    .m_axis_result_tready(m_tready)
  );

  fcmp_axis #(.CMP_OP(CMP_LT)) dut_lt (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_rdy[2]),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_rdy[2]),
    .m_axis_result_tdata(r_data[2]), .m_axis_result_tvalid(r_valid[2]),
    .m_axis_result_tready(m_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmp_op_t op_of(input int i);
    case (i)
      0:       return CMP_EQ;
      1:       return CMP_LE;
      default: return CMP_LT;
    endcase
  endfunction

  // Map each float to a signed ordering key: -mag for negatives, +mag otherwise.
  // Both zeros land on key 0; any NaN makes every relation false.
  function automatic logic ref_cmp(input cmp_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic   na, nb;
    longint ka, kb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ka = longint'({33'd0, a[30:0]});
    kb = longint'({33'd0, b[30:0]});
    if (a[31]) ka = -ka;
    if (b[31]) kb = -kb;
    if (na || nb) return 1'b0;
    case (op)
      CMP_EQ:  return ka == kb;
      CMP_LE:  return ka <= kb;
      default: return ka <  kb;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return {r[31], 8'hFF, (r[22:0] == 23'd0) ? 23'd1 : r[22:0]};
      5:       return {r[31], 8'h00, r[22:0]};
      6:       return 32'h3F80_0000;
      7:       return 32'hBF80_0000;
      8:       return {r[31], 8'h7F, 20'd0, r[2:0]};
      default: return r;
    endcase
  endfunction

  // Per-cycle compare process: record handshakes, pair operands, check results.
  task automatic monitor();
    logic [31:0] a, b;
    cyc++;
    if (!aresetn) begin
      prev_stall = 1'b0;
      a_xfer     = 1'b0;
      b_xfer     = 1'b0;
      return;
    end
    check("handshake_agree", 32'({a_rdy, b_rdy, r_valid}),
          32'({{3{a_rdy[0]}}, {3{b_rdy[0]}}, {3{r_valid[0]}}}));
    if (prev_stall) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("stall_hold[%s]", op_of(i).name()),
              32'({r_valid[i], r_data[i]}), 32'({1'b1, prev_data[i]}));
    end
    a_xfer = a_tvalid & a_rdy[0];
    b_xfer = b_tvalid & b_rdy[0];
    if (a_xfer) begin
      qa.push_back(a_tdata);
      n_a_xfer++;
    end
    if (b_xfer) qb.push_back(b_tdata);
    while (qa.size() > 0 && qb.size() > 0) begin
      ea.push_back(qa.pop_front());
      eb.push_back(qb.pop_front());
    end
    if (r_valid[0] && m_tready) begin
      n_results++;
      if (fire_first < 0) fire_first = cyc;
      fire_last = cyc;
      check("result_has_pair", 32'(ea.size() > 0), 32'd1);
      if (ea.size() > 0) begin
        a = ea.pop_front();
        b = eb.pop_front();
        for (int i = 0; i < 3; i++)
          check($sformatf("result[%s] a=%h b=%h", op_of(i).name(), a, b),
                32'(r_data[i]), 32'({7'd0, ref_cmp(op_of(i), a, b)}));
      end
    end
    prev_stall = r_valid[0] & ~m_tready;
    for (int i = 0; i < 3; i++) prev_data[i] = r_data[i];
  endtask

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic cycle();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_treadys"}, 32'({a_rdy, b_rdy}), 32'd0);
    check({tag, "_tvalid"}, 32'(r_valid), 32'd0);
    check({tag, "_tdata"}, {8'd0, r_data[0], r_data[1], r_data[2]}, 32'd0);
  endtask

  // Single pair with literal expectations; checks the two-edge latency too.
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic e_eq, input logic e_le, input logic e_lt);
    a_tdata = a; b_tdata = b; a_tvalid = 1'b1; b_tvalid = 1'b1; m_tready = 1'b1;
    #1 check({name, "_ready"}, 32'({a_rdy[0], b_rdy[0]}), 32'd3);
    cycle();                                   // E0: transfer
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    cycle();                                   // E1
    check({name, "_not_yet"}, 32'(r_valid[0]), 32'd0);
    cycle();                                   // E2
    check({name, "_valid"}, 32'(r_valid[0]), 32'd1);
    check({name, "_eq"}, 32'(r_data[0]), 32'({7'd0, e_eq}));
    check({name, "_le"}, 32'(r_data[1]), 32'({7'd0, e_le}));
    check({name, "_lt"}, 32'(r_data[2]), 32'({7'd0, e_lt}));
    cycle();                                   // consumed
  endtask

  // Supply partners for any unpaired operand and empty the pipeline.
  task automatic drain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (a_xfer) a_tvalid = 1'b0;
      if (b_xfer) b_tvalid = 1'b0;
      a_xfer = 1'b0; b_xfer = 1'b0;
      if (!a_tvalid && qb.size() > qa.size()) begin a_tvalid = 1'b1; a_tdata = rand_fp(); end
      if (!b_tvalid && qa.size() > qb.size()) begin b_tvalid = 1'b1; b_tdata = rand_fp(); end
      m_tready = 1'b1;
      #1;
      if (!a_tvalid && !b_tvalid && qa.size() == 0 && qb.size() == 0 &&
          ea.size() == 0 && !r_valid[0]) break;
      cycle();
    end
    check({name, "_drained"}, 32'(ea.size() + qa.size() + qb.size() + 32'(r_valid[0])), 32'd0);
  endtask

  initial begin
    int r0, a0;
    aresetn = 1'b0; a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b0;
    a_tdata = '0; b_tdata = '0;
    a_xfer = 1'b0; b_xfer = 1'b0; prev_stall = 1'b0;
    cyc = 0; n_results = 0; n_a_xfer = 0; fire_first = -1; fire_last = -1;

    // Reset state, with valids asserted to show nothing is taken.
    #3;
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    #1 check_reset_state("reset");
    cycle(); cycle();
    check_reset_state("reset_held");
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    aresetn = 1'b1;
    #1 check("first_cycle_treadys", 32'({a_rdy, b_rdy}), 32'h3F);

    // Literal operand pairs, including the zero, NaN, infinity and denormal edges.
    directed("lt_1_2",     32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b1);
    directed("lt_2_1",     32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    directed("pz_nz",      32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    directed("nan_1",      32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    directed("m2_m1",      32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b1, 1'b1);
    directed("inf_max",    32'h7F80_0000, 32'h7F7F_FFFF, 1'b0, 1'b0, 1'b0);
    directed("ndenorm_z",  32'h8000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    directed("denorm_eq",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b0);

    // B arrives alone and waits three cycles for A.
    r0 = n_results;
    b_tdata = 32'h3F80_0000; b_tvalid = 1'b1; m_tready = 1'b1;
    cycle();
    b_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("lone_b_treadys", 32'({a_rdy[0], b_rdy[0]}), 32'd2);
      cycle();
    end
    a_tdata = 32'hBF80_0000; a_tvalid = 1'b1;
    cycle();
    a_tvalid = 1'b0;
    cycle(); cycle();
    check("lone_b_valid", 32'(r_valid[0]), 32'd1);
    check("lone_b_lt", 32'(r_data[2]), 32'd1);
    for (int c = 0; c < 4; c++) cycle();
    check("lone_b_one_result", 32'(n_results - r0), 32'd1);

    // Four back-to-back pairs, results on consecutive cycles.
    r0 = n_results; fire_first = -1; fire_last = -1;
    for (int k = 0; k < 4; k++) begin
      a_tdata = rand_fp(); b_tdata = (k == 1) ? a_tdata : rand_fp();
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      #1 check("b2b_treadys", 32'({a_rdy[0], b_rdy[0]}), 32'd3);
      cycle();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    for (int c = 0; c < 6; c++) cycle();
    check("b2b_count", 32'(n_results - r0), 32'd4);
    check("b2b_consecutive", 32'(fire_last - fire_first), 32'd3);

    // Sustained backpressure: three pairs fill the pipe, then inputs stall.
    r0 = n_results; a0 = n_a_xfer;
    m_tready = 1'b0;
    a_tdata = rand_fp(); b_tdata = rand_fp(); a_tvalid = 1'b1; b_tvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 check("bp_treadys", 32'({a_rdy[0], b_rdy[0]}), ((n_a_xfer - a0) < 3) ? 32'd3 : 32'd0);
      cycle();
      if (a_xfer) a_tdata = rand_fp();
      if (b_xfer) b_tdata = rand_fp();
    end
    check("bp_accepted", 32'(n_a_xfer - a0), 32'd3);
    drain("bp");
    check("bp_no_loss", 32'(n_results - r0), 32'd4);

    // Reset with two pairs in flight.
    m_tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_tdata = rand_fp(); b_tdata = rand_fp(); a_tvalid = 1'b1; b_tvalid = 1'b1;
      cycle();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    cycle();
    check("pre_reset_valid", 32'(r_valid[0]), 32'd1);
    aresetn = 1'b0; a_tvalid = 1'b1; b_tvalid = 1'b1;
    qa.delete(); qb.delete(); ea.delete(); eb.delete();
    #1 check_reset_state("midflight_reset");
    cycle();
    a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
    aresetn = 1'b1;
    #1 check("post_reset_treadys", 32'({a_rdy, b_rdy}), 32'h3F);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("no_stale_result", 32'(r_valid[0]), 32'd0);
    end
    directed("post_reset", 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      if (!a_tvalid || a_xfer) begin
        a_tvalid = ($urandom_range(0, 99) < 70);
        a_tdata  = rand_fp();
      end
      if (!b_tvalid || b_xfer) begin
        b_tvalid = ($urandom_range(0, 99) < 70);
        b_tdata  = ($urandom_range(0, 3) == 0) ? a_tdata : rand_fp();
      end
      m_tready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fcmp_axis.md
FCMP_AXIS -- requirements
Module: fcmp_axis

Interface
REQ-001 The block SHALL have one parameter: CMP_OP, default CMP_EQ, selecting the compare (CMP_EQ a==b, CMP_LE a<=b, CMP_LT a<b).
REQ-002 aclk  input  1  sole clock; all state on rising edge.
REQ-003 aresetn  input  1  reset, asynchronous, active-low.
REQ-004 s_axis_a_tdata  input  32  operand A, IEEE-754 single.
REQ-005 s_axis_a_tvalid  input  1  A valid.
REQ-006 s_axis_a_tready  output  1  A accepted when valid&ready.
REQ-007 s_axis_b_tdata  input  32  operand B, IEEE-754 single.
REQ-008 s_axis_b_tvalid  input  1  B valid.
REQ-009 s_axis_b_tready  output  1  B accepted when valid&ready.
REQ-010 m_axis_result_tdata  output  8  bit0 = compare result; bits 7:1 = 0.
REQ-011 m_axis_result_tvalid  output  1  result valid.
REQ-012 m_axis_result_tready  input  1  downstream accepts result.

Function
REQ-013 A and B channels SHALL each have one independent one-entry holding register with a full flag; a transfer loads data and sets full.
REQ-014 issue SHALL be asserted when a_full & b_full & stage-1 can advance; issue clears both full flags and loads stage 1.
REQ-015 s_axis_x_tready SHALL be ~x_full | issue; a combinational path from m_axis_result_tready is permitted.
REQ-016 Advance rule: stage 2 (output register) loads when ~m_tvalid | m_tready; stage 1 advances into stage 2 under the same condition, and stage 1 refills when empty or advancing.
REQ-017 Latency: the last operand transfer at edge E0 SHALL give m_axis_result_tvalid high after edge E2, with no backpressure; throughput one result per cycle.
REQ-018 Stage 1 SHALL register operand classification: nan_a, nan_b, both_zero, sign_a, sign_b, mag_a, mag_b (bits 30:0), and a valid bit.
REQ-019 NaN is exp==8'hFF & mantissa!=0; if either operand is NaN the result SHALL be 0 for every CMP_OP.
REQ-020 +0 and -0 SHALL compare equal; denormals SHALL be compared as ordinary magnitudes without flushing; infinities SHALL be ordinary extremes.
REQ-021 Ordering: different signs -> the negative operand is less; both positive -> unsigned mag compare; both negative -> reversed mag compare.
REQ-022 While m_tvalid=1 & m_tready=0, m_axis_result_tdata SHALL stay stable and tvalid SHALL stay high.
REQ-023 Operand arriving alone SHALL be held indefinitely, with its tready low, until the other arrives; arrival order of A and B SHALL not affect pairing.
REQ-024 Under sustained backpressure, stage 2, stage 1, and both holding registers SHALL fill (three pairs in flight), then both treadys SHALL be 0.

Reset
REQ-025 aresetn low SHALL immediately clear a_full, b_full, stage-1 valid, and m_axis_result_tvalid, and SHALL zero m_axis_result_tdata.
REQ-026 Both s_axis treadys SHALL be 0 while aresetn is low; in-flight operands and results SHALL be discarded.
REQ-027 After reset release, the first cycle SHALL show both treadys = 1.

Structure
REQ-028 Package fpu_pkg SHALL hold the cmp_op_t enum (CMP_EQ, CMP_LE, CMP_LT), FP_EXP_MAX=8'hFF, and the width constants FP_W=32 and CMP_RES_W=8.
REQ-029 The one-entry holding register SHALL be a sub-module axis_hold (data, full, load, clear), instantiated for A and for B; compare logic stays in fcmp_axis.

Verification
REQ-030 CMP_LT, A=0x3F800000 (1.0), B=0x40000000 (2.0) -> tdata=0x01 two cycles after the last transfer; swapped operands -> 0x00.
REQ-031 CMP_EQ, A=0x00000000, B=0x80000000 -> 0x01; CMP_LE with A=0x7FC00000 (NaN), B=0x3F800000 -> 0x00; CMP_LT with 0xC0000000 (-2.0) < 0xBF800000 (-1.0) -> 0x01.
REQ-032 B presented 3 cycles before A -> b_tready low for those 3 cycles after the B transfer, one result only, correct pairing.
REQ-033 Four back-to-back pairs with m_tready=1 -> four results on consecutive cycles; then m_tready=0 for 6 cycles -> tdata stable, treadys drop after the 3rd pair, and no loss on release.
REQ-034 aresetn pulled low with two pairs in flight -> tvalid=0 at once, no stale result after release, and the next pair produces the correct result.
